// File: rtl/pong_pkg.sv
// Shared pong constants and types, used by the paddle input stage and the renderer.
package pong_pkg;

    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    localparam int PADDLE_HEIGHT = 50;
    localparam int PADDLE_WIDTH  = 4;
    localparam int POS_W         = 10;

    // Lowest legal paddle top row: the paddle must fit fully on screen.
    localparam int MAX_POS = SCREEN_H - PADDLE_HEIGHT;

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [POS_W:0]   pos_wide_t;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN
    } paddle_state_t;

    // Map debounced {down, up} levels to a direction; both or neither means stop.
    function automatic paddle_state_t decodeDir(input logic [1:0] db);
        paddle_state_t dir;
        case (db)
            2'b01:   dir = MOVE_UP;
            2'b10:   dir = MOVE_DOWN;
            default: dir = IDLE;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter for one raw push-button.
// The debounced level only flips after DEBOUNCE_CYCLES consecutive cycles
// of disagreement, so shorter glitches never reach the output.
module btn_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic btn_db_o
);

    logic        sync1_q, sync2_q;
    logic        db_q, db_d;
    logic [15:0] cnt_q, cnt_d;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Count cycles of disagreement and flip the debounced level once stable long enough.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
            db_d  = ~db_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Hold the counter and debounced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign btn_db_o = db_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Per-player paddle input stage: debounces up/down buttons and moves the
// paddle top row once per frame on the vsync rising edge, clamped to screen.
// Optional acceleration while a direction is held: define PADDLE_ACCEL_EN.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          SPEED_MIN       = 2,
`ifdef PADDLE_ACCEL_EN
    parameter int          SPEED_MAX       = 8,
    parameter int          ACCEL_FRAMES    = 4,
`endif
    parameter int          INIT_POS        = 215
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             vsync,
    output logic [POS_W-1:0] paddle_vpos,
    output logic [1:0]       btn_db
);

    logic          dbUp, dbDown;
    logic          vsync_q;
    logic          tick;
    paddle_state_t state_q, state_d;
    pos_t          pos_q, pos_d;
    pos_wide_t     posWide, stepWide, sumWide;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDbUp (
        .clk      (clk),
        .reset    (reset),
        .btn_i    (btn_up),
        .btn_db_o (dbUp)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDbDown (
        .clk      (clk),
        .reset    (reset),
        .btn_i    (btn_down),
        .btn_db_o (dbDown)
    );

    assign btn_db = {dbDown, dbUp};
    assign tick   = vsync & ~vsync_q;

`ifdef PADDLE_ACCEL_EN
    localparam int SPD_W  = $clog2(SPEED_MAX + 1);
    localparam int HOLD_W = $clog2(ACCEL_FRAMES + 1);

    logic [SPD_W-1:0]  speed_q, speed_d;
    logic [HOLD_W-1:0] hold_q, hold_d, holdInc;

    // Speed drops to minimum on stop or reversal and ramps while one direction is held.
    always_comb begin
        speed_d = speed_q;
        hold_d  = hold_q;
        holdInc = hold_q + 1'b1;
        if (tick) begin
            if (state_d == IDLE || state_d != state_q) begin
                speed_d = SPD_W'(SPEED_MIN);
                hold_d  = '0;
            end else if (holdInc == HOLD_W'(ACCEL_FRAMES)) begin
                hold_d = '0;
                if (speed_q < SPD_W'(SPEED_MAX)) begin
                    speed_d = speed_q + 1'b1;
                end
            end else begin
                hold_d = holdInc;
            end
        end
    end

    // Hold the speed and frame-hold counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            speed_q <= SPD_W'(SPEED_MIN);
            hold_q  <= '0;
        end else begin
            speed_q <= speed_d;
            hold_q  <= hold_d;
        end
    end
`else
    localparam int SPD_W = 4;

    logic [SPD_W-1:0] speed_d;

    assign speed_d = SPD_W'(SPEED_MIN);
`endif

    // Direction state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Re-decide direction only at the start of each frame.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            state_d = decodeDir(btn_db);
        end
    end

    // Move the paddle by the post-decision speed, clamping at both screen edges.
    always_comb begin
        pos_d    = pos_q;
        posWide  = {1'b0, pos_q};
        stepWide = pos_wide_t'(speed_d);
        sumWide  = posWide + stepWide;
        if (tick) begin
            case (state_d)
                MOVE_UP: begin
                    if (posWide < stepWide) begin
                        pos_d = '0;
                    end else begin
                        pos_d = pos_t'(posWide - stepWide);
                    end
                end
                MOVE_DOWN: begin
                    if (sumWide > pos_wide_t'(MAX_POS)) begin
                        pos_d = pos_t'(MAX_POS);
                    end else begin
                        pos_d = pos_t'(sumWide);
                    end
                end
                default: pos_d = pos_q;
            endcase
        end
    end

    // Position and vsync edge-detect registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q   <= pos_t'(INIT_POS);
            vsync_q <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            vsync_q <= vsync;
        end
    end

    assign paddle_vpos = pos_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl: directed scenarios plus random button,
// vsync and reset activity, compared every cycle against a frame-level model.
module tb_paddle_ctrl;

    localparam logic [15:0] DB_CYC  = 16'd4;
    localparam int          MAX_POS = 430;
    localparam int          INIT    = 215;
    localparam int          SPD_MIN = 2;
    localparam int          SPD_MAX = 8;
    localparam int          ACC_FR  = 4;
`ifdef PADDLE_ACCEL_EN
    localparam bit          ACCEL_ON = 1'b1;
`else
    localparam bit          ACCEL_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, btn_up, btn_down, vsync;
    logic [9:0] paddle_vpos;
    logic [1:0] btn_db;

    int checks   = 0;
    int failures = 0;

    // Reference model state: direction -1 up, +1 down, 0 stopped.
    int mPos, mDir, mSpeed, mHold;
    bit mVsPrev;
    bit mDb[2];
    int mRun[2];
    bit upQ[$];
    bit dnQ[$];

    // Frame generator state.
    int frameCycle  = 0;
    int framePeriod = 10;
    int pulseWidth  = 2;

    always #5 clk = ~clk;

    paddle_ctrl #(.DEBOUNCE_CYCLES(DB_CYC)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .vsync       (vsync),
        .paddle_vpos (paddle_vpos),
        .btn_db      (btn_db)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // A button's debounced level flips after DB_CYC consecutive disagreeing samples,
    // where samples arrive two clocks late through the synchronizer.
    task automatic settle(input int b, input bit lvl);
        if (lvl == mDb[b]) begin
            mRun[b] = 0;
        end else begin
            mRun[b]++;
            if (mRun[b] == int'(DB_CYC)) begin
                mDb[b]  = ~mDb[b];
                mRun[b] = 0;
            end
        end
    endtask

    task automatic modelStep(input bit r, input bit u, input bit d, input bit v);
        bit tick;
        int newDir;
        bit lateUp, lateDn;
        if (r) begin
            mPos = INIT; mDir = 0; mSpeed = SPD_MIN; mHold = 0; mVsPrev = 1'b0;
            mDb[0] = 1'b0; mDb[1] = 1'b0; mRun[0] = 0; mRun[1] = 0;
            upQ = '{1'b0, 1'b0};
            dnQ = '{1'b0, 1'b0};
            return;
        end
        tick = v && !mVsPrev;
        mVsPrev = v;
        if (tick) begin
            newDir = (mDb[0] && !mDb[1]) ? -1 : ((mDb[1] && !mDb[0]) ? 1 : 0);
            if (newDir == 0 || newDir != mDir) begin
                mSpeed = SPD_MIN;
                mHold  = 0;
            end else if (ACCEL_ON) begin
                mHold++;
                if (mHold == ACC_FR) begin
                    mHold  = 0;
                    mSpeed = (mSpeed + 1 > SPD_MAX) ? SPD_MAX : mSpeed + 1;
                end
            end
            mDir = newDir;
            mPos = mPos + mDir * mSpeed;
            if (mPos < 0) mPos = 0;
            if (mPos > MAX_POS) mPos = MAX_POS;
        end
        lateUp = upQ.pop_front();
        lateDn = dnQ.pop_front();
        upQ.push_back(u);
        dnQ.push_back(d);
        settle(0, lateUp);
        settle(1, lateDn);
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then compare.
    task automatic applyStimulus(input bit r, input bit u, input bit d);
        bit v;
        v        = (frameCycle < pulseWidth);
        reset    = r;
        btn_up   = u;
        btn_down = d;
        vsync    = v;
        frameCycle = (frameCycle + 1) % framePeriod;
        @(posedge clk);
        modelStep(r, u, d, v);
        #1;
        checkOutput("vpos", 32'(paddle_vpos), 32'(mPos));
        checkOutput("btn_db", 32'(btn_db), {30'd0, mDb[1], mDb[0]});
    endtask

    task automatic runFor(input int n, input bit r, input bit u, input bit d);
        for (int i = 0; i < n; i++) begin
            applyStimulus(r, u, d);
        end
    endtask

    initial begin
        reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; vsync = 1'b0;

        runFor(3, 1'b1, 1'b0, 1'b0);
        checkOutput("reset_pos", 32'(paddle_vpos), 32'd215);
        checkOutput("reset_db", 32'(btn_db), 32'd0);

        runFor(30, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_pos", 32'(paddle_vpos), 32'd215);

        runFor(40, 1'b0, 1'b1, 1'b0);
        runFor(1500, 1'b0, 1'b1, 1'b0);
        checkOutput("top_clamp", 32'(paddle_vpos), 32'd0);

        runFor(3000, 1'b0, 1'b0, 1'b1);
        checkOutput("bottom_clamp", 32'(paddle_vpos), 32'd430);

        runFor(60, 1'b0, 1'b1, 1'b1);
        runFor(20, 1'b0, 1'b0, 1'b0);

        runFor(3, 1'b0, 1'b0, 1'b1);
        runFor(20, 1'b0, 1'b0, 1'b0);
        checkOutput("glitch_db", 32'(btn_db), 32'd0);

        runFor(40, 1'b0, 1'b0, 1'b1);
        runFor(1, 1'b1, 1'b0, 1'b1);
        checkOutput("reset_mid_hold", 32'(paddle_vpos), 32'd215);
        runFor(40, 1'b0, 1'b0, 1'b1);

        for (int s = 0; s < 200; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                framePeriod = $urandom_range(5, 20);
                pulseWidth  = $urandom_range(1, 3);
                frameCycle  = 0;
            end
            runFor($urandom_range(1, 40), ($urandom_range(0, 30) == 0),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
